// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the read-master state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ADDR  = 2'b01,
        ST_DRAIN = 2'b10,
        ST_ERR   = 2'b11
    } rm_state_e;

    // An INCR burst must restart with NONSEQ when it crosses a 1 KB boundary.
    function automatic logic [1:0] next_htrans(input logic [31:0] addr);
        logic [1:0] trans;
        if (addr[9:0] == 10'd0) begin
            trans = HTRANS_NONSEQ;
        end else begin
            trans = HTRANS_SEQ;
        end
        return trans;
    endfunction

endpackage

// File: rtl/ahb_read_master.sv
// AHB-Lite INCR read master: pops start addresses from the address FIFO and
// streams the returned words toward the AXI R-channel logic.
module ahb_read_master
    import ahb_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic        rclk,
    input  logic        reset,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_data,
    output logic        fifo_read_en,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    input  logic        hready,
    input  logic        hresp,
    input  logic [31:0] hrdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        rdata_last,
    output logic        xfer_err,
    output logic        busy
);

    localparam logic [3:0] LAST_IDX = 4'(BURST_LEN - 1);

    rm_state_e   state_r;
    logic [31:0] haddr_r;
    logic [1:0]  htrans_r;
    logic [3:0]  addr_cnt_r;
    logic [3:0]  data_cnt_r;
    logic        dph_pend_r;
    logic [31:0] rdata_r;
    logic        rdata_valid_r;
    logic        rdata_last_r;
    logic        xfer_err_r;

    logic        addr_acc_s;
    logic        dph_ok_s;
    logic        dph_err_s;
    logic [31:0] haddr_inc_s;

    // A data phase is pending for every address the slave accepted on the previous hready.
    assign addr_acc_s   = hready & htrans_r[1];
    assign dph_ok_s     = hready & ~hresp & dph_pend_r & (state_r != ST_ERR);
    assign dph_err_s    = ~hready & hresp & dph_pend_r;
    assign haddr_inc_s  = haddr_r + 32'd4;
    assign fifo_read_en = (state_r == ST_IDLE) & ~fifo_empty & ~reset;

    assign haddr       = haddr_r;
    assign htrans      = htrans_r;
    assign hwrite      = 1'b0;
    assign hsize       = HSIZE_WORD;
    assign hburst      = HBURST_INCR;
    assign rdata       = rdata_r;
    assign rdata_valid = rdata_valid_r;
    assign rdata_last  = rdata_last_r;
    assign xfer_err    = xfer_err_r;
    assign busy        = (state_r != ST_IDLE);

    // Burst sequencer, address pipeline and registered read-data stream.
    always_ff @(posedge rclk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            haddr_r       <= 32'd0;
            htrans_r      <= HTRANS_IDLE;
            addr_cnt_r    <= 4'd0;
            data_cnt_r    <= 4'd0;
            dph_pend_r    <= 1'b0;
            rdata_r       <= 32'd0;
            rdata_valid_r <= 1'b0;
            rdata_last_r  <= 1'b0;
            xfer_err_r    <= 1'b0;
        end else begin
            rdata_valid_r <= 1'b0;
            rdata_last_r  <= 1'b0;
            xfer_err_r    <= 1'b0;

            if (hready) begin
                dph_pend_r <= addr_acc_s;
            end else begin
                dph_pend_r <= dph_pend_r;
            end

            if (dph_ok_s) begin
                rdata_r       <= hrdata;
                rdata_valid_r <= 1'b1;
                rdata_last_r  <= (data_cnt_r == LAST_IDX);
                data_cnt_r    <= data_cnt_r + 4'd1;
            end else begin
                rdata_r <= rdata_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (fifo_read_en) begin
                        haddr_r    <= fifo_data & 32'hFFFF_FFFC;
                        htrans_r   <= HTRANS_NONSEQ;
                        addr_cnt_r <= 4'd0;
                        data_cnt_r <= 4'd0;
                        dph_pend_r <= 1'b0;
                        state_r    <= ST_ADDR;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    if (dph_err_s) begin
                        // Withdraw the address held on the bus; the slave is mid-error.
                        htrans_r <= HTRANS_IDLE;
                        state_r  <= ST_ERR;
                    end else if (hready) begin
                        if (addr_cnt_r == LAST_IDX) begin
                            htrans_r <= HTRANS_IDLE;
                            state_r  <= ST_DRAIN;
                        end else begin
                            haddr_r    <= haddr_inc_s;
                            htrans_r   <= next_htrans(haddr_inc_s);
                            addr_cnt_r <= addr_cnt_r + 4'd1;
                        end
                    end else begin
                        state_r <= ST_ADDR;
                    end
                end
                ST_DRAIN: begin
                    if (dph_err_s) begin
                        state_r <= ST_ERR;
                    end else if (hready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_ERR: begin
                    if (hready && hresp) begin
                        xfer_err_r <= 1'b1;
                        state_r    <= ST_IDLE;
                    end else begin
                        state_r <= ST_ERR;
                    end
                end
                default: begin
                    htrans_r <= HTRANS_IDLE;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_read_master.sv
// Scoreboard bench for ahb_read_master: a small AHB slave model predicts
// address phases, read beats, pops and error pulses.
module tb_ahb_read_master;
    import ahb_pkg::*;

    localparam int BL = 4;

    logic        rclk;
    logic        reset;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        fifo_read_en;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        rdata_last;
    logic        xfer_err;
    logic        busy;

    ahb_read_master #(.BURST_LEN(BL)) dut (
        .rclk(rclk), .reset(reset),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read_en(fifo_read_en),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hready(hready), .hresp(hresp), .hrdata(hrdata),
        .rdata(rdata), .rdata_valid(rdata_valid), .rdata_last(rdata_last),
        .xfer_err(xfer_err), .busy(busy)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    typedef struct packed { logic [31:0] addr; logic [1:0] trans; } aph_t;
    typedef struct packed { logic [31:0] data; logic last; } beat_t;

    logic [31:0] fifo_q[$];
    aph_t        aph_q[$];
    beat_t       beat_q[$];

    int n_cmp = 0;
    int n_mis = 0;

    bit chk_en = 1'b0, exp_busy = 1'b0, beat_due = 1'b0, err_due = 1'b0;
    bit rst_chk = 1'b0, hold_chk = 1'b0, err_chk = 1'b0, dph_pend = 1'b0;
    logic [31:0] dph_addr = 32'd0;
    int dph_idx = 0, acc_idx = 0;
    int wait_beat = -1, wait_n = 0, wait_left = 0;
    int err_beat = -1, err_phase = 0, reset_beat = -1, rst_cyc = 0;
    logic [31:0] hold_addr;
    logic [1:0]  hold_trans;
    int cnt_pop = 0, cnt_val = 0, cnt_last = 0, cnt_err = 0;
    logic        s_rd_en;
    logic [31:0] s_haddr;
    logic [1:0]  s_htrans;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16]};
    endfunction

    // One bus cycle: check registered outputs, drive slave/FIFO, update the model at the edge.
    task automatic cycle();
        logic [31:0] base;
        logic [31:0] a;
        beat_t b;
        aph_t  ap;
        if (chk_en) begin
            chk("rdata_valid", 32'(rdata_valid), 32'(beat_due));
            if (beat_due) begin
                b = beat_q.pop_front();
                chk("rdata", rdata, b.data);
                chk("rdata_last", 32'(rdata_last), 32'(b.last));
            end
            chk("xfer_err", 32'(xfer_err), 32'(err_due));
            chk("busy", 32'(busy), 32'(exp_busy));
            if (err_chk) chk("err_cancel_htrans", 32'(htrans), 32'(HTRANS_IDLE));
            if (hold_chk) begin
                chk("hold_haddr", haddr, hold_addr);
                chk("hold_htrans", 32'(htrans), 32'(hold_trans));
            end
            if (rst_chk) begin
                chk("rst_haddr", haddr, 32'd0);
                chk("rst_htrans", 32'(htrans), 32'(HTRANS_IDLE));
                chk("rst_rdata", rdata, 32'd0);
                chk("rst_rdata_last", 32'(rdata_last), 32'd0);
            end
            if (rdata_valid === 1'b1) cnt_val++;
            if (rdata_last === 1'b1) cnt_last++;
            if (xfer_err === 1'b1) cnt_err++;
        end
        beat_due = 1'b0; err_due = 1'b0; err_chk = 1'b0; hold_chk = 1'b0; rst_chk = 1'b0;

        reset = 1'b0;
        if (rst_cyc > 0) begin
            reset = 1'b1;
            rst_cyc--;
        end else if (dph_pend && reset_beat >= 0 && dph_idx == reset_beat) begin
            reset = 1'b1;
            reset_beat = -1;
        end
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = dph_pend ? mem_word(dph_addr) : 32'hDEAD_BEEF;
        if (dph_pend && !reset) begin
            if (err_phase == 1) hresp = 1'b1;
            else if (dph_idx == err_beat) begin hready = 1'b0; hresp = 1'b1; end
            else if (dph_idx == wait_beat && wait_left > 0) hready = 1'b0;
        end
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 32'h0 : fifo_q[0];

        #1;
        s_rd_en  = fifo_read_en;
        s_haddr  = haddr;
        s_htrans = htrans;
        if (chk_en) chk("fifo_read_en", 32'(fifo_read_en), 32'(!exp_busy && !fifo_empty && !reset));

        @(posedge rclk);
        if (reset) begin
            aph_q.delete();
            beat_q.delete();
            dph_pend = 1'b0; exp_busy = 1'b0; err_phase = 0;
            rst_chk = 1'b1; chk_en = 1'b1;
        end else begin
            if (s_rd_en === 1'b1 && fifo_q.size() != 0) begin
                base = fifo_q.pop_front() & 32'hFFFF_FFFC;
                cnt_pop++;
                exp_busy = 1'b1;
                acc_idx = 0;
                for (int i = 0; i < BL; i++) begin
                    a = base + 32'(4 * i);
                    ap.addr  = a;
                    ap.trans = (i == 0 || a[9:0] == 10'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
                    aph_q.push_back(ap);
                end
            end
            if (hready) begin
                if (dph_pend) begin
                    if (!hresp) begin
                        b.data = mem_word(dph_addr);
                        b.last = (dph_idx == BL - 1);
                        beat_q.push_back(b);
                        beat_due = 1'b1;
                        if (dph_idx == BL - 1) exp_busy = 1'b0;
                        if (dph_idx == wait_beat) wait_beat = -1;
                    end else begin
                        err_due = 1'b1; exp_busy = 1'b0; aph_q.delete();
                        err_phase = 0; err_beat = -1;
                    end
                end
                if (s_htrans[1] === 1'b1) begin
                    if (aph_q.size() == 0) begin
                        chk("spurious_htrans", 32'(s_htrans), 32'(HTRANS_IDLE));
                    end else begin
                        ap = aph_q.pop_front();
                        chk("haddr", s_haddr, ap.addr);
                        chk("htrans", 32'(s_htrans), 32'(ap.trans));
                    end
                    dph_pend = 1'b1;
                    dph_addr = s_haddr;
                    dph_idx  = acc_idx;
                    acc_idx++;
                    if (dph_idx == wait_beat) wait_left = wait_n;
                end else begin
                    dph_pend = 1'b0;
                end
            end else if (dph_pend && hresp) begin
                err_phase = 1;
                err_chk = 1'b1;
            end else begin
                if (dph_pend && dph_idx == wait_beat) wait_left--;
                hold_chk = 1'b1; hold_addr = s_haddr; hold_trans = s_htrans;
            end
        end
        @(negedge rclk);
    endtask

    task automatic run_txn(input string tag, input int e_pop, input int e_val,
                           input int e_last, input int e_err);
        int budget;
        budget = 300;
        cnt_pop = 0; cnt_val = 0; cnt_last = 0; cnt_err = 0;
        while ((fifo_q.size() != 0 || exp_busy || beat_due || err_due || rst_chk) && budget > 0) begin
            cycle();
            budget--;
        end
        cycle();
        cycle();
        if (budget == 0) chk({tag, "_timeout"}, 32'(budget), 32'd1);
        chk({tag, "_pops"}, 32'(cnt_pop), 32'(e_pop));
        chk({tag, "_valids"}, 32'(cnt_val), 32'(e_val));
        chk({tag, "_lasts"}, 32'(cnt_last), 32'(e_last));
        chk({tag, "_xfer_errs"}, 32'(cnt_err), 32'(e_err));
    endtask

    initial begin
        reset = 1'b1; fifo_empty = 1'b1; fifo_data = 32'd0;
        hready = 1'b1; hresp = 1'b0; hrdata = 32'd0;
        rst_cyc = 2;
        cycle();
        cycle();
        chk("hwrite", 32'(hwrite), 32'd0);
        chk("hsize", 32'(hsize), 32'(HSIZE_WORD));
        chk("hburst", 32'(hburst), 32'(HBURST_INCR));
        repeat (4) cycle();

        fifo_q.push_back(32'h1000_0003);
        run_txn("incr4", 1, 4, 1, 0);

        fifo_q.push_back(32'h0000_03F8);
        run_txn("kb_cross", 1, 4, 1, 0);

        fifo_q.push_back(32'hFFFF_FFF8);
        run_txn("wrap", 1, 4, 1, 0);

        wait_beat = 1; wait_n = 2;
        fifo_q.push_back(32'h2000_0010);
        run_txn("wait2", 1, 4, 1, 0);

        err_beat = 1;
        fifo_q.push_back(32'h3000_0000);
        fifo_q.push_back(32'h3000_0100);
        run_txn("error", 2, 5, 1, 1);

        reset_beat = 2;
        fifo_q.push_back(32'h4000_0000);
        fifo_q.push_back(32'h4000_0040);
        run_txn("mid_reset", 2, 6, 1, 0);

        fifo_q.push_back(32'h5000_0000);
        fifo_q.push_back(32'h5000_1004);
        fifo_q.push_back(32'h5000_23F0);
        run_txn("back2back", 3, 12, 3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
